// File: rtl/dense_pkg.sv
// Shared types and helpers for the dense-layer accumulate/requantise stages.
// Holds the FSM state type, a constant-folding clog2 and the shift-and-clip rule.
package dense_pkg;

  typedef enum logic {
    ACCUM,
    OUT
  } state_t;

  localparam int DEF_OUT_W = 16;
  localparam int OUT_MAX   = 2 ** (DEF_OUT_W - 1) - 1;
  localparam int OUT_MIN   = -(2 ** (DEF_OUT_W - 1));

  // Working width of sat_trunc; callers sign-extend into it and slice back out.
  localparam int SAT_W = 64;

  typedef struct packed {
    logic             sat;
    logic [SAT_W-1:0] value;
  } sat_res_t;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

  function automatic sat_res_t sat_trunc(input logic signed [SAT_W-1:0] acc,
                                         input int shift, input int out_w);
    sat_res_t                r;
    logic signed [SAT_W-1:0] q;
    logic signed [SAT_W-1:0] hi;
    logic signed [SAT_W-1:0] lo;
    q  = acc >>> shift;
    hi = (64'sd1 <<< (out_w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (out_w - 1));
    r.sat   = 1'b0;
    r.value = q;
    if (q > hi) begin
      r.sat   = 1'b1;
      r.value = hi;
    end else if (q < lo) begin
      r.sat   = 1'b1;
      r.value = lo;
    end
    return r;
  endfunction

endpackage

// File: rtl/dense_requant_sat.sv
// Combinational requantiser: arithmetic right shift (floor) then clip to a
// signed OUT_W-bit range, flagging when the clip was applied.
module dense_requant_sat
  import dense_pkg::*;
#(
  parameter int ACC_W = 32,
  parameter int SHIFT = 10,
  parameter int OUT_W = 16
) (
  input  logic [ACC_W-1:0] i_acc,
  output logic [OUT_W-1:0] o_data,
  output logic             o_sat
);

  if (ACC_W > SAT_W || OUT_W >= SAT_W) begin : g_width_check
    $error("dense_requant_sat: ACC_W/OUT_W exceed the sat_trunc working width");
  end

  sat_res_t w_res;
  logic     w_unused;

  assign w_res    = sat_trunc(SAT_W'($signed(i_acc)), SHIFT, OUT_W);
  assign o_data   = w_res.value[OUT_W-1:0];
  assign o_sat    = w_res.sat;
  // Upper bits are a sign extension of o_data once clipped.
  assign w_unused = ^w_res.value[SAT_W-1:OUT_W];

endmodule

// File: rtl/dense_accum_requant.sv
// Accumulates N_IN signed products onto a bias-seeded neuron sum, requantises
// the final sum with saturation and holds it on a valid/ready output register.
module dense_accum_requant
  import dense_pkg::*;
#(
  parameter int PROD_W = 26,
  parameter int N_IN   = 16,
  parameter int ACC_W  = 32,
  parameter int BIAS_W = 16,
  parameter int OUT_W  = 16,
  parameter int SHIFT  = 10
) (
  input  logic              ap_clk,
  input  logic              ap_rst,
  input  logic [PROD_W-1:0] prod_in,
  input  logic [BIAS_W-1:0] bias_in,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [OUT_W-1:0]  out_data,
  output logic              out_sat,
  output logic              out_valid,
  input  logic              out_ready
);

  localparam int CNT_W = (clog2(N_IN) < 1) ? 1 : clog2(N_IN);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N_IN - 1);

  if (N_IN < 2) begin : g_nin_check
    $error("dense_accum_requant: N_IN must be at least 2");
  end
  if (ACC_W < PROD_W + clog2(N_IN) + 1) begin : g_acc_check
    $error("dense_accum_requant: ACC_W too narrow for N_IN products of PROD_W bits");
  end

  state_t             r_state;
  state_t             w_state_next;
  logic [CNT_W-1:0]   r_cnt;
  logic [CNT_W-1:0]   w_cnt_next;
  logic [ACC_W-1:0]   r_acc;
  logic [ACC_W-1:0]   w_acc_next;
  logic [ACC_W-1:0]   w_prod_ext;
  logic [ACC_W-1:0]   w_seed;
  logic               w_accept;
  logic               w_last;
  logic [OUT_W-1:0]   w_q;
  logic               w_q_sat;
  logic [OUT_W-1:0]   r_out_data;
  logic               r_out_sat;
  logic               r_out_valid;

  assign in_ready   = (r_state == ACCUM);
  assign w_accept   = in_valid && in_ready;
  assign w_last     = w_accept && (r_cnt == CNT_LAST);
  assign w_prod_ext = ACC_W'($signed(prod_in));
  // The first beat of a neuron replaces the old sum with the scaled bias.
  assign w_seed     = (r_cnt == '0) ? (ACC_W'($signed(bias_in)) <<< SHIFT) : r_acc;

  // NOTE: every output of this block is given a default first, so no path
  // leaves a signal unassigned and no latch is inferred.
  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_acc_next   = r_acc;
    case (r_state)
      ACCUM: begin
        if (w_accept) begin
          w_acc_next = w_seed + w_prod_ext;
          if (r_cnt == CNT_LAST) begin
            w_cnt_next   = '0;
            w_state_next = OUT;
          end else begin
            w_cnt_next = r_cnt + CNT_W'(1);
          end
        end
      end
      OUT: begin
        if (out_ready) w_state_next = ACCUM;
      end
    endcase
  end

  dense_requant_sat #(
    .ACC_W (ACC_W),
    .SHIFT (SHIFT),
    .OUT_W (OUT_W)
  ) u_requant (
    .i_acc  (w_acc_next),
    .o_data (w_q),
    .o_sat  (w_q_sat)
  );

  // NOTE: state is updated with non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      r_state     <= ACCUM;
      r_cnt       <= '0;
      r_acc       <= '0;
      r_out_data  <= '0;
      r_out_sat   <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      r_acc   <= w_acc_next;
      if (w_last) begin
        r_out_data  <= w_q;
        r_out_sat   <= w_q_sat;
        r_out_valid <= 1'b1;
      end else if (r_out_valid && out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign out_data  = r_out_data;
  assign out_sat   = r_out_sat;
  assign out_valid = r_out_valid;

endmodule
